// File: rtl/tst_din_pkg.sv
// Shared types and constants for the multi-channel AXI4-Stream test-data source.
// The LFSR helpers are only referenced when TST_DIN_LFSR_EN is defined.
package tst_din_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STOP = 2'd2,
        DONE = 2'd3
    } tst_state_e;

    localparam logic [31:0] LFSR_POLY   = 32'h8020_0003;
    localparam int          CH_FIELD_W  = 8;
    localparam int          ITE_FIELD_W = 8;

    // Right-shifting Galois form: feedback taps are XORed in when bit 0 falls out.
    function automatic logic [31:0] lfsr_step(input logic [31:0] x);
        return x[0] ? ((x >> 1) ^ LFSR_POLY) : (x >> 1);
    endfunction

    // An all-zero state would lock the LFSR, so substitute 1.
    function automatic logic [31:0] lfsr_seed(input logic [31:0] seed, input int unsigned ch);
        logic [31:0] s;
        s = seed ^ 32'(ch);
        return (s == 32'd0) ? 32'd1 : s;
    endfunction

endpackage

// File: rtl/tst_din_gen_if.sv
// Bundle of NCH parallel AXI4-Stream channels driven by tst_din_gen.
interface tst_din_gen_if #(
    parameter int NCH = 4,
    parameter int DW  = 64
) ();
    logic [NCH*DW-1:0] tdata;
    logic [NCH-1:0]    tvalid;
    logic [NCH-1:0]    tready;
    logic [NCH-1:0]    tlast;

    modport master (output tdata, output tvalid, output tlast, input  tready);
    modport slave  (input  tdata, input  tvalid, input  tlast, output tready);
endinterface

// File: rtl/tst_din_chan.sv
// One output channel: sample counter, valid/last generation, data pattern, frame-done flag.
// TST_DIN_LFSR_EN selects LFSR data instead of the ramp pattern.
module tst_din_chan
    import tst_din_pkg::*;
#(
    parameter int DW        = 64,
    parameter int FRAME_LEN = 1024,
    parameter int CH        = 0
`ifdef TST_DIN_LFSR_EN
    ,
    parameter logic [31:0] SEED = 32'hACE1_2024
`endif
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clear,
    input  logic                   launch,
    input  logic                   frame_release,
`ifndef TST_DIN_LFSR_EN
    input  logic [ITE_FIELD_W-1:0] ite_lsb,
`endif
    input  logic                   tready,
    output logic                   tvalid,
    output logic                   tlast,
    output logic [DW-1:0]          tdata,
    output logic                   frame_done
);

    localparam int              IDXW     = $clog2(FRAME_LEN);
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(FRAME_LEN - 1);

    logic            active_reg;
    logic            done_reg;
    logic [IDXW-1:0] idx_reg;
    logic            handshake;
    logic            at_last;

    assign handshake = active_reg & tready;
    assign at_last   = (idx_reg == LAST_IDX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active_reg <= 1'b0;
            done_reg   <= 1'b0;
            idx_reg    <= '0;
        end else if (clear) begin
            active_reg <= 1'b0;
            done_reg   <= 1'b0;
            idx_reg    <= '0;
        end else if (launch) begin
            active_reg <= 1'b1;
            done_reg   <= 1'b0;
            idx_reg    <= '0;
        end else begin
            if (frame_release) begin
                done_reg <= 1'b0;
            end
            // After the last beat the channel parks until the whole group finishes.
            if (handshake) begin
                if (at_last) begin
                    active_reg <= 1'b0;
                    done_reg   <= 1'b1;
                    idx_reg    <= '0;
                end else begin
                    idx_reg <= idx_reg + 1'b1;
                end
            end
        end
    end

    assign tvalid     = active_reg;
    assign tlast      = active_reg & at_last;
    assign frame_done = done_reg;

`ifdef TST_DIN_LFSR_EN
    localparam logic [31:0] CH_SEED = lfsr_seed(SEED, CH);

    logic [31:0] lfsr_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_reg <= CH_SEED;
        end else if (clear) begin
            lfsr_reg <= CH_SEED;
        end else if (handshake) begin
            lfsr_reg <= lfsr_step(lfsr_reg);
        end
    end

    assign tdata = active_reg ? {(DW/32){lfsr_reg}} : '0;
`else
    localparam int PAD_W = DW - CH_FIELD_W - ITE_FIELD_W;

    assign tdata = active_reg ? {CH_FIELD_W'(CH), ite_lsb, PAD_W'(idx_reg)} : '0;
`endif

endmodule

// File: rtl/tst_din_gen.sv
// Multi-channel AXI4-Stream test-data source: run FSM, start edge detect, frame lockstep, iteration count.
// Define TST_DIN_LFSR_EN for per-channel LFSR data; the default build emits a ramp pattern.
module tst_din_gen
    import tst_din_pkg::*;
#(
    parameter int          NCH       = 4,
    parameter int          DW        = 64,
    parameter int          FRAME_LEN = 1024,
    parameter logic [31:0] SEED      = 32'hACE1_2024
) (
    input  logic           clk_aie,
    input  logic           rst_aie,
    input  logic           test_en_aie,
    input  logic [31:0]    num_ite_aie,
    tst_din_gen_if.master  m_axis,
    output logic [31:0]    itecnt_aie,
    output logic           busy_aie,
    output logic           done_aie
);

    tst_state_e  state_reg;
    logic        test_en_d_reg;
    logic [31:0] itecnt_reg;
    logic        busy_reg;
    logic        done_reg;

    logic [NCH-1:0]    chan_valid;
    logic [NCH-1:0]    chan_last;
    logic [NCH-1:0]    chan_done;
    logic [DW-1:0]     chan_data [NCH];
    logic [NCH*DW-1:0] tdata_all;

    logic        all_done;
    logic        none_active;
    logic        start;
    logic        hit;
    logic        launch;
    logic [31:0] itecnt_inc;

    always_comb begin
        all_done    = &chan_done;
        none_active = ~|chan_valid;
        itecnt_inc  = (itecnt_reg == 32'hFFFF_FFFF) ? itecnt_reg : itecnt_reg + 32'd1;
        hit         = (num_ite_aie != 32'd0) && (itecnt_inc == num_ite_aie);
        // The start edge is only honoured from IDLE.
        start       = (state_reg == IDLE) && test_en_aie && !test_en_d_reg;
        // First frame after entry, or the next frame right at a boundary if the run continues.
        launch      = (state_reg == RUN) && test_en_aie &&
                      ((none_active && !(|chan_done)) || (all_done && !hit));
    end

    always_ff @(posedge clk_aie or posedge rst_aie) begin
        if (rst_aie) begin
            state_reg     <= IDLE;
            test_en_d_reg <= 1'b1;
            itecnt_reg    <= '0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            test_en_d_reg <= test_en_aie;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        state_reg  <= RUN;
                        itecnt_reg <= '0;
                        busy_reg   <= 1'b1;
                    end
                end
                RUN: begin
                    if (all_done) begin
                        itecnt_reg <= itecnt_inc;
                        if (hit) begin
                            state_reg <= DONE;
                            busy_reg  <= 1'b0;
                            done_reg  <= 1'b1;
                        end else if (!test_en_aie) begin
                            state_reg <= STOP;
                        end
                    end else if (!test_en_aie) begin
                        state_reg <= STOP;
                    end
                end
                STOP: begin
                    if (none_active) begin
                        if (all_done) begin
                            itecnt_reg <= itecnt_inc;
                        end
                        state_reg <= IDLE;
                        busy_reg  <= 1'b0;
                    end
                end
                DONE: begin
                    if (!test_en_aie) begin
                        state_reg <= IDLE;
                        done_reg  <= 1'b0;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                    done_reg  <= 1'b0;
                end
            endcase
        end
    end

    for (genvar gi = 0; gi < NCH; gi++) begin : g_chan
        tst_din_chan #(
            .DW        (DW),
            .FRAME_LEN (FRAME_LEN),
            .CH        (gi)
`ifdef TST_DIN_LFSR_EN
            ,
            .SEED      (SEED)
`endif
        ) u_chan (
            .clk           (clk_aie),
            .rst           (rst_aie),
            .clear         (start),
            .launch        (launch),
            .frame_release (all_done),
`ifndef TST_DIN_LFSR_EN
            .ite_lsb       (itecnt_reg[ITE_FIELD_W-1:0]),
`endif
            .tready        (m_axis.tready[gi]),
            .tvalid        (chan_valid[gi]),
            .tlast         (chan_last[gi]),
            .tdata         (chan_data[gi]),
            .frame_done    (chan_done[gi])
        );
    end

    always_comb begin
        tdata_all = '0;
        for (int c = 0; c < NCH; c++) begin
            tdata_all[c*DW +: DW] = chan_data[c];
        end
    end

    assign m_axis.tdata  = tdata_all;
    assign m_axis.tvalid = chan_valid;
    assign m_axis.tlast  = chan_last;
    assign itecnt_aie    = itecnt_reg;
    assign busy_aie      = busy_reg;
    assign done_aie      = done_reg;

endmodule
